rs_age_issue_queue: RTL and testbench

- Parametrised reservation station for the out-of-order core; holds renamed ops between dispatch and one functional unit.
- Captures operands from CDB_PORTS broadcast ports, including same-cycle capture during allocation.
- Issues the oldest ready entry over a valid/ready handshake.
- Supports ROB-tag-range flush with wrap-around.

---
 rtl/rs_age_issue_queue.sv | 164 ++++++++++++++++
 tb/tb_rs_age_issue_queue.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/rs_age_issue_queue.sv
// Age-ordered reservation station: CDB operand wakeup (with alloc bypass),
// oldest-ready issue over valid/ready, and wrap-aware ROB-tag-range flush.
module rs_age_issue_queue #(
   parameter int DEPTH     = 8,
   parameter int TAG_W     = 4,
   parameter int DATA_W    = 32,
   parameter int OP_W      = 6,
   parameter int CDB_PORTS = 2
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          flush_valid,
   input  logic [TAG_W-1:0]              flush_front_tag,
   input  logic [TAG_W-1:0]              flush_end_tag,
   input  logic                          alloc_valid,
   output logic                          alloc_ready,
   input  logic [TAG_W-1:0]              alloc_tag,
   input  logic [OP_W-1:0]               alloc_op,
   input  logic                          alloc_src1_busy,
   input  logic [DATA_W-1:0]             alloc_src1,
   input  logic                          alloc_src2_busy,
   input  logic [DATA_W-1:0]             alloc_src2,
   input  logic [CDB_PORTS-1:0]          cdb_valid,
   input  logic [CDB_PORTS*TAG_W-1:0]    cdb_tag,
   input  logic [CDB_PORTS*DATA_W-1:0]   cdb_data,
   output logic                          issue_valid,
   input  logic                          issue_ready,
   output logic [TAG_W-1:0]              issue_tag,
   output logic [OP_W-1:0]               issue_op,
   output logic [DATA_W-1:0]             issue_src1,
   output logic [DATA_W-1:0]             issue_src2,
   output logic [$clog2(DEPTH):0]        num_free
);
   localparam int IDX_W = $clog2(DEPTH);
   localparam int CNT_W = IDX_W + 1;

   logic [DEPTH-1:0]              valid_q, valid_d;
   logic [DEPTH-1:0]              busy1_q, busy1_d, busy2_q, busy2_d;
   logic [DEPTH-1:0][TAG_W-1:0]   tag_q, tag_d;
   logic [DEPTH-1:0][OP_W-1:0]    op_q, op_d;
   logic [DEPTH-1:0][DATA_W-1:0]  src1_q, src1_d, src2_q, src2_d;
   // older_q[i][j] set: entry j was allocated before entry i
   logic [DEPTH-1:0][DEPTH-1:0]   older_q, older_d;

   logic [DEPTH-1:0] ready;
   logic             sel_found, free_found;
   logic [IDX_W-1:0] sel_idx, free_idx;
   logic [CNT_W-1:0] free_cnt;
   logic             alloc_fire, issue_fire;

   // Returns {busy, value}; lowest matching port wins.
   function automatic logic [DATA_W:0] wake(
      input logic                        busy,
      input logic [DATA_W-1:0]           src,
      input logic [CDB_PORTS-1:0]        cv,
      input logic [CDB_PORTS*TAG_W-1:0]  ct,
      input logic [CDB_PORTS*DATA_W-1:0] cd
   );
      logic [DATA_W:0] res;
      res = {busy, src};
      for (int p = CDB_PORTS-1; p >= 0; p--) begin
         if (busy && cv[p] && (ct[p*TAG_W +: TAG_W] == src[TAG_W-1:0]))
            res = {1'b0, cd[p*DATA_W +: DATA_W]};
      end
      return res;
   endfunction

   function automatic logic in_range(
      input logic [TAG_W-1:0] t,
      input logic [TAG_W-1:0] f,
      input logic [TAG_W-1:0] e
   );
      if (f == e)     return 1'b0;
      else if (f < e) return (t >= f) && (t < e);
      else            return (t >= f) || (t < e);
   endfunction

   assign ready = valid_q & ~busy1_q & ~busy2_q;

   always_comb begin
      sel_found  = 1'b0;
      sel_idx    = '0;
      free_found = 1'b0;
      free_idx   = '0;
      free_cnt   = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (ready[i] && !sel_found && ((ready & older_q[i]) == '0)) begin
            sel_found = 1'b1;
            sel_idx   = IDX_W'(i);
         end
         if (!valid_q[i]) begin
            free_cnt = free_cnt + CNT_W'(1);
            if (!free_found) begin
               free_found = 1'b1;
               free_idx   = IDX_W'(i);
            end
         end
      end
   end

   assign num_free    = free_cnt;
   assign alloc_ready = (free_cnt != '0);
   assign issue_valid = sel_found && !flush_valid;
   assign issue_tag   = tag_q[sel_idx];
   assign issue_op    = op_q[sel_idx];
   assign issue_src1  = src1_q[sel_idx];
   assign issue_src2  = src2_q[sel_idx];

   assign alloc_fire = alloc_valid && alloc_ready && !flush_valid;
   assign issue_fire = issue_valid && issue_ready;

   always_comb begin
      valid_d = valid_q;
      busy1_d = busy1_q;
      busy2_d = busy2_q;
      tag_d   = tag_q;
      op_d    = op_q;
      src1_d  = src1_q;
      src2_d  = src2_q;
      older_d = older_q;
      for (int i = 0; i < DEPTH; i++) begin
         if (valid_q[i]) begin
            {busy1_d[i], src1_d[i]} = wake(busy1_q[i], src1_q[i], cdb_valid, cdb_tag, cdb_data);
            {busy2_d[i], src2_d[i]} = wake(busy2_q[i], src2_q[i], cdb_valid, cdb_tag, cdb_data);
            if (flush_valid && in_range(tag_q[i], flush_front_tag, flush_end_tag))
               valid_d[i] = 1'b0;
         end
      end
      if (issue_fire)
         valid_d[sel_idx] = 1'b0;
      // The alloc slot is free in valid_q, so no wakeup above touched it.
      if (alloc_fire) begin
         valid_d[free_idx] = 1'b1;
         tag_d[free_idx]   = alloc_tag;
         op_d[free_idx]    = alloc_op;
         {busy1_d[free_idx], src1_d[free_idx]} = wake(alloc_src1_busy, alloc_src1, cdb_valid, cdb_tag, cdb_data);
         {busy2_d[free_idx], src2_d[free_idx]} = wake(alloc_src2_busy, alloc_src2, cdb_valid, cdb_tag, cdb_data);
         for (int j = 0; j < DEPTH; j++) begin
            older_d[free_idx][j] = valid_q[j] && !(issue_fire && (IDX_W'(j) == sel_idx));
            older_d[j][free_idx] = 1'b0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q <= '0;
         older_q <= '0;
      end else begin
         valid_q <= valid_d;
         older_q <= older_d;
      end
   end

   always_ff @(posedge clk) begin
      busy1_q <= busy1_d;
      busy2_q <= busy2_d;
      tag_q   <= tag_d;
      op_q    <= op_d;
      src1_q  <= src1_d;
      src2_q  <= src2_d;
   end

endmodule

// File: tb/tb_rs_age_issue_queue.sv
// Scoreboard bench for rs_age_issue_queue: expected issues are queued as ops
// are dispatched and compared when the FU handshake completes.
module tb_rs_age_issue_queue;
   logic        clk, rst;
   logic        flush_valid;
   logic [3:0]  flush_front_tag, flush_end_tag;
   logic        alloc_valid, alloc_ready;
   logic [3:0]  alloc_tag;
   logic [5:0]  alloc_op;
   logic        alloc_src1_busy, alloc_src2_busy;
   logic [31:0] alloc_src1, alloc_src2;
   logic [1:0]  cdb_valid;
   logic [7:0]  cdb_tag;
   logic [63:0] cdb_data;
   logic        issue_valid, issue_ready;
   logic [3:0]  issue_tag;
   logic [5:0]  issue_op;
   logic [31:0] issue_src1, issue_src2;
   logic [3:0]  num_free;

   typedef struct packed {
      logic [3:0]  tag;
      logic [31:0] s1;
      logic [31:0] s2;
   } exp_t;
   exp_t sb[$];

   int n_tests = 0;
   int n_fail  = 0;

   rs_age_issue_queue dut (
      .clk(clk), .rst(rst),
      .flush_valid(flush_valid), .flush_front_tag(flush_front_tag), .flush_end_tag(flush_end_tag),
      .alloc_valid(alloc_valid), .alloc_ready(alloc_ready), .alloc_tag(alloc_tag), .alloc_op(alloc_op),
      .alloc_src1_busy(alloc_src1_busy), .alloc_src1(alloc_src1),
      .alloc_src2_busy(alloc_src2_busy), .alloc_src2(alloc_src2),
      .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
      .issue_valid(issue_valid), .issue_ready(issue_ready), .issue_tag(issue_tag), .issue_op(issue_op),
      .issue_src1(issue_src1), .issue_src2(issue_src2), .num_free(num_free)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic alloc(input logic [3:0] t, input logic b1, input logic [31:0] s1,
                        input logic b2, input logic [31:0] s2);
      alloc_valid     = 1'b1;
      alloc_tag       = t;
      alloc_op        = {2'b00, t};
      alloc_src1_busy = b1;
      alloc_src1      = s1;
      alloc_src2_busy = b2;
      alloc_src2      = s2;
      step();
      alloc_valid = 1'b0;
   endtask

   // Issue handshake monitor: inputs are stable between posedge+1 and the next posedge.
   always @(negedge clk) begin
      if (!rst && issue_valid && issue_ready) begin
         if (sb.size() == 0) begin
            chk("unexpected_issue_tag", {60'd0, issue_tag}, 64'hFFFF);
         end else begin
            exp_t e;
            e = sb.pop_front();
            chk("issue_tag",  {60'd0, issue_tag},  {60'd0, e.tag});
            chk("issue_src1", {32'd0, issue_src1}, {32'd0, e.s1});
            chk("issue_src2", {32'd0, issue_src2}, {32'd0, e.s2});
         end
      end
   end

   initial begin
      rst = 1'b1; flush_valid = 1'b0; flush_front_tag = '0; flush_end_tag = '0;
      alloc_valid = 1'b0; alloc_tag = '0; alloc_op = '0;
      alloc_src1_busy = 1'b0; alloc_src1 = '0; alloc_src2_busy = 1'b0; alloc_src2 = '0;
      cdb_valid = '0; cdb_tag = '0; cdb_data = '0; issue_ready = 1'b0;
      step(); step();
      rst = 1'b0;
      chk("reset_num_free", 64'(num_free), 64'd8);
      chk("reset_alloc_ready", 64'(alloc_ready), 64'd1);
      chk("reset_issue_valid", 64'(issue_valid), 64'd0);

      // Basic alloc -> issue
      issue_ready = 1'b1;
      sb.push_back('{tag: 4'd3, s1: 32'd5, s2: 32'd7});
      alloc(4'd3, 1'b0, 32'd5, 1'b0, 32'd7);
      chk("basic_issue_valid", 64'(issue_valid), 64'd1);
      chk("basic_issue_tag", 64'(issue_tag), 64'd3);
      step();
      chk("basic_num_free", 64'(num_free), 64'd8);
      chk("basic_idle", 64'(issue_valid), 64'd0);

      // Wakeup from CDB port1; younger ready op issues first
      issue_ready = 1'b0;
      alloc(4'd1, 1'b1, 32'd9, 1'b0, 32'h11);
      alloc(4'd2, 1'b0, 32'h22, 1'b0, 32'h33);
      chk("wake_first_sel", 64'(issue_tag), 64'd2);
      sb.push_back('{tag: 4'd2, s1: 32'h22, s2: 32'h33});
      sb.push_back('{tag: 4'd1, s1: 32'hAA, s2: 32'h11});
      cdb_valid = 2'b10; cdb_tag = {4'd9, 4'd0}; cdb_data = {32'hAA, 32'h0};
      issue_ready = 1'b1;
      step();
      cdb_valid = '0;
      chk("wake_second_valid", 64'(issue_valid), 64'd1);
      chk("wake_second_sel", 64'(issue_tag), 64'd1);
      step();
      chk("wake_num_free", 64'(num_free), 64'd8);

      // Alloc bypass from CDB port0
      sb.push_back('{tag: 4'd5, s1: 32'd1, s2: 32'h55});
      cdb_valid = 2'b01; cdb_tag = {4'd0, 4'd4}; cdb_data = {32'h0, 32'h55};
      alloc(4'd5, 1'b0, 32'd1, 1'b1, 32'd4);
      cdb_valid = '0;
      chk("bypass_issue_valid", 64'(issue_valid), 64'd1);
      chk("bypass_issue_tag", 64'(issue_tag), 64'd5);
      step();

      // Full queue; overflow alloc ignored; freed slot reused
      for (int i = 0; i < 8; i++)
         alloc(4'(i), 1'b1, 32'(i + 8), 1'b0, 32'h100 + 32'(i));
      chk("full_num_free", 64'(num_free), 64'd0);
      chk("full_alloc_ready", 64'(alloc_ready), 64'd0);
      chk("full_issue_valid", 64'(issue_valid), 64'd0);
      alloc(4'd12, 1'b0, 32'hC1, 1'b0, 32'hC2);
      chk("full_overflow_ignored", 64'(num_free), 64'd0);
      sb.push_back('{tag: 4'd3, s1: 32'h33, s2: 32'h103});
      cdb_valid = 2'b01; cdb_tag = {4'd0, 4'd11}; cdb_data = {32'h0, 32'h33};
      step();
      cdb_valid = '0;
      chk("full_woken_sel", 64'(issue_tag), 64'd3);
      step();
      chk("full_freed_ready", 64'(alloc_ready), 64'd1);
      chk("full_freed_num", 64'(num_free), 64'd1);
      sb.push_back('{tag: 4'd13, s1: 32'hD1, s2: 32'hD2});
      alloc(4'd13, 1'b0, 32'hD1, 1'b0, 32'hD2);
      chk("refill_num_free", 64'(num_free), 64'd0);
      chk("refill_sel", 64'(issue_tag), 64'd13);
      step();
      // Reset mid-operation with live CDB beats
      rst = 1'b1;
      cdb_valid = 2'b11; cdb_tag = {4'd9, 4'd8}; cdb_data = {32'h99, 32'h88};
      step();
      rst = 1'b0; cdb_valid = '0;
      chk("midrst_num_free", 64'(num_free), 64'd8);
      chk("midrst_issue_valid", 64'(issue_valid), 64'd0);

      // Wrap-around flush; concurrent alloc must be suppressed
      issue_ready = 1'b0;
      alloc(4'd14, 1'b0, 32'hE0, 1'b0, 32'hE1);
      alloc(4'd15, 1'b0, 32'hF0, 1'b0, 32'hF1);
      alloc(4'd0,  1'b0, 32'h00, 1'b0, 32'h01);
      alloc(4'd1,  1'b0, 32'h10, 1'b0, 32'h11);
      alloc(4'd2,  1'b0, 32'h20, 1'b0, 32'h21);
      chk("flush_pre_sel", 64'(issue_tag), 64'd14);
      chk("flush_pre_num", 64'(num_free), 64'd3);
      flush_valid = 1'b1; flush_front_tag = 4'd15; flush_end_tag = 4'd1;
      alloc_valid = 1'b1; alloc_tag = 4'd7; alloc_src1_busy = 1'b0; alloc_src2_busy = 1'b0;
      #1;
      chk("flush_issue_blocked", 64'(issue_valid), 64'd0);
      step();
      flush_valid = 1'b0; alloc_valid = 1'b0;
      chk("flush_num_free", 64'(num_free), 64'd5);
      sb.push_back('{tag: 4'd14, s1: 32'hE0, s2: 32'hE1});
      sb.push_back('{tag: 4'd1,  s1: 32'h10, s2: 32'h11});
      sb.push_back('{tag: 4'd2,  s1: 32'h20, s2: 32'h21});
      issue_ready = 1'b1;
      step(); step(); step();
      chk("flush_drain_num", 64'(num_free), 64'd8);

      // Empty flush range, then non-wrapping range
      issue_ready = 1'b0;
      alloc(4'd5, 1'b0, 32'h5A, 1'b0, 32'h5B);
      flush_valid = 1'b1; flush_front_tag = 4'd5; flush_end_tag = 4'd5;
      step();
      chk("flush_empty_range", 64'(num_free), 64'd7);
      flush_front_tag = 4'd4; flush_end_tag = 4'd6;
      step();
      flush_valid = 1'b0;
      chk("flush_linear_range", 64'(num_free), 64'd8);

      // Back-pressure hold
      alloc(4'd6, 1'b0, 32'h66, 1'b0, 32'h77);
      for (int i = 0; i < 3; i++) begin
         chk("hold_valid", 64'(issue_valid), 64'd1);
         chk("hold_tag", 64'(issue_tag), 64'd6);
         chk("hold_src1", 64'(issue_src1), 64'h66);
         chk("hold_num_free", 64'(num_free), 64'd7);
         step();
      end
      sb.push_back('{tag: 4'd6, s1: 32'h66, s2: 32'h77});
      issue_ready = 1'b1;
      step();
      chk("hold_release_num", 64'(num_free), 64'd8);
      chk("hold_release_valid", 64'(issue_valid), 64'd0);
      issue_ready = 1'b0;
      step();
      chk("scoreboard_empty", 64'(sb.size()), 64'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
